tan_angle_reduce: RTL and testbench

TAN_ANGLE_REDUCE -- requirements
Module: tan_angle_reduce

---
 rtl/tan_angle_reduce.sv | 100 ++++++++++
 tb/tb_tan_angle_reduce.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tan_angle_reduce.sv
// Range reduction for a CORDIC tangent: folds any Q16.16 angle into [0, pi/2]
// and reports whether the tangent must be negated and whether it is near the pole.
module tan_angle_reduce #(
  parameter logic [31:0] PI       = 32'd205887,
  parameter logic [31:0] HALF_PI  = 32'd102944,
  parameter logic [31:0] POLE_EPS = 32'd64,
  parameter int          STEPS    = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] xita_in,
  output logic        busy,
  output logic        valid,
  output logic [31:0] xita_out,
  output logic        neg,
  output logic        pole
);

  localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {IDLE, ABS, REDUCE, FOLD, DONE} state_t;

  state_t        state, state_next;
  logic [31:0]   xin;
  logic [32:0]   a;
  logic [KW-1:0] k;
  logic          sgn;

  logic [32:0] pi33, half33, eps33, pi_shift;
  logic [32:0] r;
  logic        fold_c, neg_c, pole_c;

  assign pi33     = {1'b0, PI};
  assign half33   = {1'b0, HALF_PI};
  assign eps33    = {1'b0, POLE_EPS};
  assign pi_shift = pi33 << k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ABS;
      ABS:     state_next = REDUCE;
      REDUCE:  if (k == '0) state_next = FOLD;
      FOLD:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final fold into the first quadrant; r never exceeds HALF_PI, so the pole
  // distance below cannot wrap.
  always_comb begin
    fold_c = (a > half33);
    r      = fold_c ? (pi33 - a) : a;
    neg_c  = (sgn ^ fold_c) && (r != '0);
    pole_c = ((half33 - r) <= eps33);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xin      <= '0;
      a        <= '0;
      k        <= '0;
      sgn      <= 1'b0;
      xita_out <= '0;
      neg      <= 1'b0;
      pole     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) xin <= xita_in;
        ABS: begin
          sgn <= xin[31];
          a   <= xin[31] ? ({1'b0, ~xin} + 33'd1) : {1'b0, xin};
          k   <= KW'(STEPS - 1);
        end
        REDUCE: begin
          if (a >= pi_shift) a <= a - pi_shift;
          k <= k - KW'(1);
        end
        // Results are registered on entry to DONE so they are stable with valid.
        FOLD: begin
          xita_out <= r[31:0];
          neg      <= neg_c;
          pole     <= pole_c;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_tan_angle_reduce.sv
// Directed, table-driven bench for tan_angle_reduce: latency, results,
// output holding, ignored starts and mid-operation reset.
module tb_tan_angle_reduce;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] xita_in;
  logic        busy;
  logic        valid;
  logic [31:0] xita_out;
  logic        neg;
  logic        pole;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_out;
  logic        last_neg;
  logic        last_pole;

  typedef struct {
    logic [31:0] xin;
    logic [31:0] exp_out;
    logic        exp_neg;
    logic        exp_pole;
  } vec_t;

  vec_t vecs [8];

  tan_angle_reduce dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .xita_in  (xita_in),
    .busy     (busy),
    .valid    (valid),
    .xita_out (xita_out),
    .neg      (neg),
    .pole     (pole)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Call just after a negedge while the DUT is idle.
  task automatic applyStimulus(input logic [31:0] xin, input logic [31:0] eo,
                               input logic en, input logic ep, input string name);
    int cyc;
    start   = 1'b1;
    xita_in = xin;
    cyc     = 0;
    @(posedge clk);
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      xita_in = $urandom;
      if (cyc == 1) checkOutput({name, " busy_after_accept"}, busy, 1);
      if (cyc == 10) begin
        checkOutput({name, " hold_out"}, xita_out, last_out);
        checkOutput({name, " hold_neg"}, neg, last_neg);
        checkOutput({name, " hold_pole"}, pole, last_pole);
      end
      if (valid) break;
    end
    checkOutput({name, " latency"}, cyc, 17);
    checkOutput({name, " busy_on_done"}, busy, 1);
    checkOutput({name, " xita_out"}, xita_out, eo);
    checkOutput({name, " neg"}, neg, en);
    checkOutput({name, " pole"}, pole, ep);
    last_out  = eo;
    last_neg  = en;
    last_pole = ep;
    @(negedge clk);
    checkOutput({name, " valid_one_cycle"}, valid, 0);
    checkOutput({name, " busy_idle"}, busy, 0);
  endtask

  initial begin
    int nvalid;

    vecs[0] = '{32'd51472,     32'd51472,  1'b0, 1'b0};
    vecs[1] = '{32'hFFFF36F0,  32'd51472,  1'b1, 1'b0};
    vecs[2] = '{32'd206887,    32'd1000,   1'b0, 1'b0};
    vecs[3] = '{32'd616661,    32'd1000,   1'b1, 1'b0};
    vecs[4] = '{32'd102934,    32'd102934, 1'b0, 1'b1};
    vecs[5] = '{32'd0,         32'd0,      1'b0, 1'b0};
    vecs[6] = '{32'h80000000,  32'd82238,  1'b1, 1'b0};
    vecs[7] = '{32'd617661,    32'd0,      1'b0, 1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    xita_in = '0;
    last_out  = '0;
    last_neg  = 1'b0;
    last_pole = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset valid", valid, 0);
    checkOutput("reset xita_out", xita_out, 0);
    checkOutput("reset neg", neg, 0);
    checkOutput("reset pole", pole, 0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls start in the IDLE cycle right after DONE (18-cycle cadence).
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].xin, vecs[i].exp_out, vecs[i].exp_neg, vecs[i].exp_pole,
                    $sformatf("vec%0d", i));
    end

    // Starts during busy are ignored.
    @(negedge clk);
    start   = 1'b1;
    xita_in = 32'd206887;
    @(posedge clk);
    nvalid = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start   = (c == 3 || c == 9);
      xita_in = 32'd51472;
      if (valid) begin
        nvalid++;
        checkOutput("ignore latency", c, 17);
        checkOutput("ignore xita_out", xita_out, 32'd1000);
        checkOutput("ignore neg", neg, 0);
      end
    end
    start = 1'b0;
    checkOutput("ignore valid_count", nvalid, 1);
    last_out  = 32'd1000;
    last_neg  = 1'b0;
    last_pole = 1'b0;

    // Reset during REDUCE aborts the request.
    @(negedge clk);
    start   = 1'b1;
    xita_in = 32'hFFFF36F0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst valid", valid, 0);
    checkOutput("midrst xita_out", xita_out, 0);
    checkOutput("midrst neg", neg, 0);
    checkOutput("midrst pole", pole, 0);
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    checkOutput("midrst no_valid", nvalid, 0);
    last_out  = '0;
    last_neg  = 1'b0;
    last_pole = 1'b0;

    applyStimulus(32'd51472, 32'd51472, 1'b0, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
